// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and response codes for the UART transmit-path arbiter.
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {IDLE, SEND, WAIT, GAP} tx_arb_state_t;

  localparam logic [7:0] RESP_DONE = 8'hA5;
  localparam logic [7:0] RESP_BUSY = 8'h5A;

  // Index width that stays at least one bit wide for tiny requester counts.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and UART_wrapper signals of the transmit arbiter; slave = arbiter side.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 3
);
  logic [N_REQ-1:0]   req;
  logic [8*N_REQ-1:0] req_byte;
  logic [N_REQ-1:0]   ack;
  logic               trmt;
  logic [7:0]         tx_data;
  logic               tx_done;
  logic               busy;
  logic               timeout;

  modport master (output req, req_byte, tx_done,
                  input  ack, trmt, tx_data, busy, timeout);
  modport slave  (input  req, req_byte, tx_done,
                  output ack, trmt, tx_data, busy, timeout);
endinterface

// File: rtl/uart_tx_arbiter_rr.sv
// Combinational round-robin picker with optional fixed priority for requester 0.
module rr_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int  N_REQ = 3,
  parameter bit  PRIO0 = 1'b1,
  localparam int IW    = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IW-1:0]    i_rr_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [IW-1:0]    o_idx,
  output logic             o_valid
);

  logic [IW:0]   w_sum;
  logic [IW-1:0] w_pos;
  logic          w_found;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = |i_req;
    w_found = 1'b0;
    w_sum   = '0;
    w_pos   = '0;
    if (PRIO0 && i_req[0]) begin
      o_grant[0] = 1'b1;
      w_found    = 1'b1;
    end
    // Walk cyclically from the pointer; the first set bit wins.
    for (int k = 0; k < N_REQ; k++) begin
      w_sum = {1'b0, i_rr_ptr} + (IW+1)'(k);
      if (w_sum >= (IW+1)'(N_REQ)) w_sum = w_sum - (IW+1)'(N_REQ);
      w_pos = w_sum[IW-1:0];
      if (!w_found && i_req[w_pos]) begin
        o_grant[w_pos] = 1'b1;
        o_idx          = w_pos;
        w_found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares the UART transmit path among N_REQ byte sources, paced by an inter-byte gap.
// States: IDLE pick winner | SEND trmt+ack | WAIT tx_done or timeout | GAP pacing.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ   = 3,
  parameter bit PRIO0   = 1'b1,
  parameter int GAP_CYC = 16,
  parameter int TO_CYC  = 2**20
) (
  input logic              clk,
  input logic              rst,
  uart_tx_arbiter_if.slave bus
);

  localparam int IW = idx_w(N_REQ);
  localparam int TW = $clog2(TO_CYC + 1);
  localparam int GW = $clog2(GAP_CYC + 1);

  tx_arb_state_t    r_state;
  logic [IW-1:0]    r_rr_ptr;
  logic [IW-1:0]    r_winner;
  logic [N_REQ-1:0] r_grant;
  logic [N_REQ-1:0] r_ack;
  logic [7:0]       r_tx_data;
  logic             r_trmt;
  logic             r_busy;
  logic             r_timeout;
  logic [TW-1:0]    r_to_cnt;
  logic [GW-1:0]    r_gap_cnt;

  logic [N_REQ-1:0] w_grant;
  logic [IW-1:0]    w_idx;
  logic             w_valid;
  logic [7:0]       w_byte;

  rr_arbiter #(.N_REQ(N_REQ), .PRIO0(PRIO0)) u_rr (
    .i_req    (bus.req),
    .i_rr_ptr (r_rr_ptr),
    .o_grant  (w_grant),
    .o_idx    (w_idx),
    .o_valid  (w_valid)
  );

  always_comb begin
    w_byte = 8'h00;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_idx == IW'(k)) w_byte = bus.req_byte[8*k +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_rr_ptr  <= '0;
      r_winner  <= '0;
      r_grant   <= '0;
      r_ack     <= '0;
      r_tx_data <= 8'h00;
      r_trmt    <= 1'b0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
      r_to_cnt  <= '0;
      r_gap_cnt <= '0;
    end else begin
      r_trmt    <= 1'b0;
      r_ack     <= '0;
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_winner  <= w_idx;
            r_grant   <= w_grant;
            r_tx_data <= w_byte;
            r_busy    <= 1'b1;
            r_state   <= SEND;
          end
        end
        SEND: begin
          r_trmt   <= 1'b1;
          r_ack    <= r_grant;
          r_rr_ptr <= (r_winner == IW'(N_REQ-1)) ? '0 : r_winner + 1'b1;
          r_to_cnt <= '0;
          r_state  <= WAIT;
        end
        WAIT: begin
          // A tx_done on the expiry cycle takes precedence over the timeout.
          if (bus.tx_done) begin
            r_gap_cnt <= '0;
            r_state   <= GAP;
          end else if (r_to_cnt == TW'(TO_CYC-1)) begin
            r_timeout <= 1'b1;
            r_gap_cnt <= '0;
            r_state   <= GAP;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        GAP: begin
          if (r_gap_cnt == GW'(GAP_CYC-1)) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.ack     = r_ack;
  assign bus.trmt    = r_trmt;
  assign bus.tx_data = r_tx_data;
  assign bus.busy    = r_busy;
  assign bus.timeout = r_timeout;

endmodule
